// File: rtl/wb_uart_pkg.sv
// Shared constants, FSM encoding and Wishbone drive bundle for the UART TX arbiter.
// Combinational helpers only: no latency, no flow control.
package wb_uart_pkg;

  localparam logic [1:0] UART_SETUP_ADDR  = 2'b00;
  localparam logic [1:0] UART_TXDATA_ADDR = 2'b11;
  localparam logic [3:0] WB_SEL_ALL       = 4'b1111;

  typedef enum logic [2:0] {
    ST_SETUP    = 3'd0,
    ST_TX_REQ   = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_GAP      = 3'd3,
    ST_IDLE     = 3'd4
  } state_e;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [1:0]  addr;
    logic [31:0] dat;
  } wb_req_t;

  // Full-word write beat with strobe raised.
  function automatic wb_req_t wb_write(input logic [1:0] addr, input logic [31:0] dat);
    wb_req_t r;
    r.cyc  = 1'b1;
    r.stb  = 1'b1;
    r.we   = 1'b1;
    r.sel  = WB_SEL_ALL;
    r.addr = addr;
    r.dat  = dat;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first request at or above the pointer, wrapping at N_REQ.
// Purely combinational (0 cycles); the caller owns the pointer and any backpressure.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic             o_any,
  output logic [N_REQ-1:0] o_gnt,
  output logic [PW-1:0]    o_idx
);

  logic [PW:0]   sum;
  logic [PW-1:0] cand;

  always_comb begin
    o_any = 1'b0;
    o_gnt = '0;
    o_idx = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // Explicit wrap so non-power-of-2 N_REQ never indexes past the top requester.
      sum = {1'b0, i_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N_REQ)) begin
        sum = sum - (PW+1)'(N_REQ);
      end
      cand = sum[PW-1:0];
      if (!o_any && i_req[cand]) begin
        o_any       = 1'b1;
        o_gnt[cand] = 1'b1;
        o_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/wb_uart_tx_arbiter.sv
// Wishbone master sharing one wbuart TX among N_REQ byte sources; writes baud setup once after reset.
// Grant to strobe is 1 clock; stall holds stb, then a GAP_CYCLES quiet period throttles bytes into the UART.
module wb_uart_tx_arbiter
  import wb_uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int BAUD_DIV    = 434,
  parameter int GAP_CYCLES  = 1500,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_data,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic               o_wb_cyc,
  output logic               o_wb_stb,
  output logic               o_wb_we,
  output logic [3:0]         o_wb_sel,
  output logic [1:0]         o_wb_addr,
  output logic [31:0]        o_wb_data,
  input  logic               i_wb_ack,
  input  logic               i_wb_stall,
  output logic               o_busy,
  output logic               o_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_e           state_q, state_d;
  wb_req_t          wb_q, wb_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [N_REQ-1:0] ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             gnt_any;
  logic [N_REQ-1:0] gnt;
  logic [PW-1:0]    gnt_idx;
  logic [7:0]       gnt_byte;
  logic             accept;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_req (i_req_valid),
    .i_ptr (ptr_q),
    .o_any (gnt_any),
    .o_gnt (gnt),
    .o_idx (gnt_idx)
  );

  always_comb begin
    gnt_byte = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        gnt_byte = gnt_byte | i_req_data[8*k +: 8];
      end
    end
  end

  assign accept = wb_q.stb & ~i_wb_stall;

  always_comb begin
    state_d = state_q;
    wb_d    = wb_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    ready_d = '0;
    err_d   = err_q;

    unique case (state_q)
      ST_SETUP: begin
        wb_d    = wb_write(UART_SETUP_ADDR, 32'(BAUD_DIV));
        tmo_d   = '0;
        state_d = ST_WAIT_ACK;
      end

      ST_IDLE: begin
        if (gnt_any) begin
          wb_d    = wb_write(UART_TXDATA_ADDR, {24'd0, gnt_byte});
          ready_d = gnt;
          ptr_d   = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
          tmo_d   = '0;
          state_d = ST_TX_REQ;
        end
      end

      // TX_REQ is the first bus cycle of a data write, so it obeys the same handshake as WAIT_ACK.
      ST_TX_REQ, ST_WAIT_ACK: begin
        state_d = ST_WAIT_ACK;
        if (i_wb_ack) begin
          wb_d    = '0;
          gap_d   = '0;
          state_d = ST_GAP;
        end else if (accept) begin
          wb_d.stb = 1'b0;
          tmo_d    = '0;
        end else if (!wb_q.stb) begin
          if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
            wb_d    = '0;
            err_d   = 1'b1;
            gap_d   = '0;
            state_d = ST_GAP;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end

      ST_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Reset also drops an in-flight cyc/stb on the same edge; any late ack then finds cyc low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_SETUP;
      wb_q    <= '0;
      ptr_q   <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      ready_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign o_req_ready = ready_q;
  assign o_wb_cyc    = wb_q.cyc;
  assign o_wb_stb    = wb_q.stb;
  assign o_wb_we     = wb_q.we;
  assign o_wb_sel    = wb_q.sel;
  assign o_wb_addr   = wb_q.addr;
  assign o_wb_data   = wb_q.dat;
  assign o_busy      = busy_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_wb_uart_tx_arbiter.sv
// Bench for wb_uart_tx_arbiter: Wishbone slave model, requester driver and write scoreboard.
// Expected writes are queued when a request is made and popped when the bus accepts a strobe.
module tb_wb_uart_tx_arbiter;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [3:0]  i_req_valid = '0;
  logic [31:0] i_req_data = '0;
  logic [3:0]  o_req_ready;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [3:0]  o_wb_sel;
  logic [1:0]  o_wb_addr;
  logic [31:0] o_wb_data;
  logic        i_wb_ack = 1'b0;
  logic        i_wb_stall = 1'b0;
  logic        o_busy, o_err;

  int n_cmp = 0;
  int n_fail = 0;

  exp_t exp_q[$];
  int   grant_log[$];
  int   wr_time[$];
  int   cyc_n = 0;
  int   stb_cnt = 0;
  int   cyc_only_cnt = 0;

  int stall_left = 0;
  int ack_lat = 2;
  int pending = 0;
  bit no_ack = 1'b0;
  bit extra_ack = 1'b0;

  wb_uart_tx_arbiter #(
    .N_REQ(4), .BAUD_DIV(434), .GAP_CYCLES(1500), .ACK_TIMEOUT(255)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data), .o_req_ready(o_req_ready),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Slave: optional stall count, then ack after ack_lat cycles (0 = same cycle as acceptance).
  always @(posedge clk) begin
    #1;
    i_wb_ack   = extra_ack;
    i_wb_stall = 1'b0;
    if (pending > 0) begin
      pending--;
      if (pending == 0) i_wb_ack = 1'b1;
    end
    if (o_wb_cyc && o_wb_stb) begin
      if (stall_left > 0) begin
        i_wb_stall = 1'b1;
        stall_left--;
      end else if (!no_ack) begin
        if (ack_lat == 0) i_wb_ack = 1'b1;
        else pending = ack_lat;
      end
    end
  end

  // Monitor: grant log, write scoreboard and strobe/cycle occupancy counters.
  always @(negedge clk) begin
    exp_t e;
    cyc_n++;
    if (o_wb_stb) stb_cnt++;
    if (o_wb_cyc && !o_wb_stb) cyc_only_cnt++;
    if (o_req_ready != 4'b0000) begin
      n_cmp++;
      if (!$onehot(o_req_ready)) begin
        n_fail++;
        $display("FAIL ready_onehot: got %b required one-hot", o_req_ready);
      end
      for (int k = 0; k < 4; k++) if (o_req_ready[k]) grant_log.push_back(k);
    end
    if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
      wr_time.push_back(cyc_n);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%b data=%h required no write", o_wb_addr, o_wb_data);
      end else begin
        e = exp_q.pop_front();
        if ({o_wb_we, o_wb_sel, o_wb_addr, o_wb_data} !== {1'b1, 4'hf, e.addr, e.data}) begin
          n_fail++;
          $display("FAIL write_beat: we=%b sel=%h addr=%b data=%h required we=1 sel=f addr=%b data=%h",
                   o_wb_we, o_wb_sel, o_wb_addr, o_wb_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input logic [1:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic clear_logs();
    grant_log.delete();
    wr_time.delete();
    stb_cnt = 0;
    cyc_only_cnt = 0;
  endtask

  // Raise one requester with a byte and hold it until its ready pulse.
  task automatic req_byte(input int k, input logic [7:0] b);
    int n = 0;
    @(posedge clk); #1;
    i_req_valid[k] = 1'b1;
    i_req_data[8*k +: 8] = b;
    push_exp(2'b11, {24'd0, b});
    @(negedge clk);
    while (!o_req_ready[k] && n < 100) begin @(negedge clk); n++; end
    n_cmp++;
    if (!o_req_ready[k]) begin
      n_fail++;
      $display("FAIL req%0d_ready_timeout: ready=%b required bit %0d set", k, o_req_ready, k);
    end
    @(posedge clk); #1;
    i_req_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (o_busy && n < 4000) begin @(negedge clk); n++; end
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: o_busy=%b required 0", tag, o_busy);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_addr, o_wb_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: cyc=%b stb=%b we=%b sel=%h addr=%b data=%h required all 0",
               o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_addr, o_wb_data);
    end
    n_cmp++;
    if ({o_req_ready, o_busy, o_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_status: ready=%b busy=%b err=%b required 0", o_req_ready, o_busy, o_err);
    end
  endtask

  task automatic test_setup();
    int n = 0;
    int gap = 0;
    clear_logs();
    ack_lat = 2;
    push_exp(2'b00, 32'd434);
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(negedge clk);
    while (!(o_wb_cyc && i_wb_ack) && n < 100) begin @(negedge clk); n++; end
    n_cmp++;
    if (!(o_wb_cyc && i_wb_ack)) begin
      n_fail++;
      $display("FAIL setup_ack_timeout: cyc=%b ack=%b required both 1", o_wb_cyc, i_wb_ack);
    end
    n = 0;
    @(negedge clk);
    while (o_busy && n < 4000) begin
      if (!o_wb_cyc) gap++;
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (gap != 1500 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL setup_gap: gap=%0d busy=%b required gap=1500 busy=0", gap, o_busy);
    end
    n_cmp++;
    if (wr_time.size() != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL setup_once: writes=%0d pending=%0d required 1 and 0", wr_time.size(), exp_q.size());
    end
  endtask

  task automatic test_single();
    clear_logs();
    @(posedge clk); #1;
    i_req_valid[1] = 1'b1;
    i_req_data[15:8] = 8'h66;
    push_exp(2'b11, 32'h0000_0066);
    @(negedge clk);
    n_cmp++;
    if (o_req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_early_ready: ready=%b required 0000", o_req_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (o_req_ready !== 4'b0010 || !o_wb_cyc || !o_wb_stb || o_wb_addr !== 2'b11 || o_wb_data !== 32'h66) begin
      n_fail++;
      $display("FAIL single_grant: ready=%b cyc=%b stb=%b addr=%b data=%h required 0010 1 1 11 00000066",
               o_req_ready, o_wb_cyc, o_wb_stb, o_wb_addr, o_wb_data);
    end
    @(posedge clk); #1;
    i_req_valid[1] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o_req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_ready_pulse: ready=%b required 0000", o_req_ready);
    end
    wait_idle("single");
    n_cmp++;
    if (grant_log.size() != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_done: grants=%0d pending=%0d required 1 and 0", grant_log.size(), exp_q.size());
    end
  endtask

  task automatic test_fairness();
    int n = 0;
    @(posedge clk); #1;
    i_rst = 1'b1;
    push_exp(2'b00, 32'd434);
    @(posedge clk); #1;
    i_rst = 1'b0;
    repeat (2) @(negedge clk);
    wait_idle("fair_setup");
    clear_logs();
    @(posedge clk); #1;
    i_req_data = {8'h44, 8'h43, 8'h42, 8'h41};
    i_req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) push_exp(2'b11, {24'd0, 8'h41 + 8'(k % 4)});
    while (grant_log.size() < 5 && n < 12000) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    i_req_valid = 4'b0000;
    wait_idle("fair");
    n_cmp++;
    if (grant_log.size() != 5) begin
      n_fail++;
      $display("FAIL fair_grant_count: got %0d required 5", grant_log.size());
    end
    for (int k = 0; k < grant_log.size() && k < 5; k++) begin
      n_cmp++;
      if (grant_log[k] != k % 4) begin
        n_fail++;
        $display("FAIL fair_order[%0d]: got %0d required %0d", k, grant_log[k], k % 4);
      end
    end
    for (int k = 1; k < wr_time.size(); k++) begin
      n_cmp++;
      if (wr_time[k] - wr_time[k-1] < 1500) begin
        n_fail++;
        $display("FAIL fair_spacing[%0d]: got %0d clocks required >=1500", k, wr_time[k] - wr_time[k-1]);
      end
    end
    n_cmp++;
    if (wr_time.size() != 5 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL fair_writes: writes=%0d pending=%0d required 5 and 0", wr_time.size(), exp_q.size());
    end
  endtask

  task automatic test_stall();
    clear_logs();
    stall_left = 5;
    ack_lat = 0;
    req_byte(3, 8'h5a);
    wait_idle("stall");
    ack_lat = 2;
    n_cmp++;
    if (stb_cnt != 6) begin
      n_fail++;
      $display("FAIL stall_stb_len: got %0d clocks required 6", stb_cnt);
    end
    n_cmp++;
    if (wr_time.size() != 1 || exp_q.size() != 0 || grant_log.size() != 1) begin
      n_fail++;
      $display("FAIL stall_single_write: writes=%0d pending=%0d grants=%0d required 1 0 1",
               wr_time.size(), exp_q.size(), grant_log.size());
    end
  endtask

  task automatic test_timeout();
    clear_logs();
    no_ack = 1'b1;
    req_byte(0, 8'h11);
    wait_idle("timeout");
    n_cmp++;
    if (cyc_only_cnt != 255) begin
      n_fail++;
      $display("FAIL timeout_len: cyc held %0d clocks after acceptance required 255", cyc_only_cnt);
    end
    n_cmp++;
    if (o_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_err: got %b required 1", o_err);
    end
    no_ack = 1'b0;
    ack_lat = 2;
    req_byte(2, 8'h22);
    wait_idle("after_timeout");
    n_cmp++;
    if (o_err !== 1'b1 || exp_q.size() != 0 || grant_log.size() != 2) begin
      n_fail++;
      $display("FAIL timeout_recover: err=%b pending=%0d grants=%0d required 1 0 2",
               o_err, exp_q.size(), grant_log.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    no_ack = 1'b1;
    req_byte(3, 8'h33);
    @(negedge clk);
    n_cmp++;
    if (o_wb_cyc !== 1'b1 || o_wb_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_wait_ack: cyc=%b stb=%b required 1 0", o_wb_cyc, o_wb_stb);
    end
    i_rst = 1'b1;
    push_exp(2'b00, 32'd434);
    @(negedge clk);
    n_cmp++;
    if ({o_wb_cyc, o_wb_stb, o_err, o_busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rmid_drop: cyc=%b stb=%b err=%b busy=%b required 0000", o_wb_cyc, o_wb_stb, o_err, o_busy);
    end
    wr_time.delete();
    extra_ack = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o_wb_cyc !== 1'b0 || i_wb_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_late_ack: cyc=%b ack=%b required 0 1", o_wb_cyc, i_wb_ack);
    end
    extra_ack = 1'b0;
    no_ack = 1'b0;
    ack_lat = 2;
    i_rst = 1'b0;
    wait_idle("rmid");
    n_cmp++;
    if (wr_time.size() != 1 || exp_q.size() != 0 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_resetup: writes=%0d pending=%0d err=%b required 1 0 0",
               wr_time.size(), exp_q.size(), o_err);
    end
  endtask

  initial begin
    test_reset();
    test_setup();
    test_single();
    test_fairness();
    test_stall();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
